sensor_stream_source: RTL and testbench

- Synthesizable sensor front-end model. Produces the `sensor_out`/`sensor_ready` stream consumed by `original_sensor_ctrl`.
- Sits directly upstream of the sensor controller, in the `dram_clk` domain.
- Replaces ad-hoc bench stimulus with a preloadable word buffer and a programmable per-sample latency, gated by the controller's `sensor_en`.

---
 rtl/sensor_stream_source_if.sv | 27 ++
 rtl/sensor_stream_source.sv | 97 +++++++++
 tb/tb_sensor_stream_source.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sensor_stream_source_if.sv
// rtl/sensor_stream_source_if.sv - request, preload and sample-stream signals of the sensor source
interface sensor_stream_source_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              sensor_en;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              sensor_ready;
  logic [DATA_W-1:0] sensor_out;
  logic [ADDR_W-1:0] rd_idx;
  logic [15:0]       sample_cnt;
  logic              wrapped;

  // Controller / preload side: requests samples and fills the buffer
  modport master (
    output sensor_en, load_we, load_addr, load_data,
    input  sensor_ready, sensor_out, rd_idx, sample_cnt, wrapped
  );

  // Sensor source side
  modport slave (
    input  sensor_en, load_we, load_addr, load_data,
    output sensor_ready, sensor_out, rd_idx, sample_cnt, wrapped
  );
endinterface

// File: rtl/sensor_stream_source.sv
// rtl/sensor_stream_source.sv - preloadable sample buffer presented with a fixed per-sample latency
module sensor_stream_source #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 16
) (
  input logic                  clk,
  input logic                  rst,
  sensor_stream_source_if.slave bus
);

  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, COUNT, PAUSE, EMIT} state_t;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [15:0]       sample_cnt_q, sample_cnt_d;
  logic              wrapped_q, wrapped_d;
  logic [DATA_W-1:0] sensor_out_q, sensor_out_d;

  // Sample buffer; contents survive reset so a preload outlives a restart
  logic [DATA_W-1:0] mem [DEPTH];
  logic              load_ok;

  assign load_ok = bus.load_we && (32'(bus.load_addr) < DEPTH);

  // Preload port; out-of-range indices and writes during reset are dropped
  always_ff @(posedge clk) begin
    if (!rst && load_ok) begin
      mem[bus.load_addr[IDX_W-1:0]] <= bus.load_data;
    end
  end

  // Next-state: count enabled cycles, emit on the last one, hold while disabled
  always_comb begin
    state_d      = IDLE;
    lat_cnt_d    = lat_cnt_q;
    rd_idx_d     = rd_idx_q;
    sample_cnt_d = sample_cnt_q;
    wrapped_d    = wrapped_q;
    sensor_out_d = '0;
    if (bus.sensor_en) begin
      if (lat_cnt_q == LAT_LAST) begin
        state_d      = EMIT;
        lat_cnt_d    = '0;
        // Read sees the pre-write value when a preload hits the same entry
        sensor_out_d = mem[rd_idx_q[IDX_W-1:0]];
        if (rd_idx_q == IDX_LAST) begin
          rd_idx_d  = '0;
          wrapped_d = 1'b1;
        end else begin
          rd_idx_d = rd_idx_q + ADDR_W'(1);
        end
        if (sample_cnt_q != 16'hFFFF) begin
          sample_cnt_d = sample_cnt_q + 16'd1;
        end
      end else begin
        state_d   = COUNT;
        lat_cnt_d = lat_cnt_q + LAT_W'(1);
      end
    end else begin
      state_d = (lat_cnt_q != '0) ? PAUSE : IDLE;
    end
  end

  // State and output registers; reset clears everything except the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      rd_idx_q     <= '0;
      sample_cnt_q <= '0;
      wrapped_q    <= 1'b0;
      sensor_out_q <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      rd_idx_q     <= rd_idx_d;
      sample_cnt_q <= sample_cnt_d;
      wrapped_q    <= wrapped_d;
      sensor_out_q <= sensor_out_d;
    end
  end

  assign bus.sensor_ready = (state_q == EMIT);
  assign bus.sensor_out   = sensor_out_q;
  assign bus.rd_idx       = rd_idx_q;
  assign bus.sample_cnt   = sample_cnt_q;
  assign bus.wrapped      = wrapped_q;

endmodule

// File: tb/tb_sensor_stream_source.sv
// tb/tb_sensor_stream_source.sv - directed table and sequence checks for sensor_stream_source
module tb_sensor_stream_source;

  logic clk;
  logic rst_a;
  logic rst_b;

  sensor_stream_source_if #(.DATA_W(32), .ADDR_W(9)) bus_a ();
  sensor_stream_source_if #(.DATA_W(32), .ADDR_W(3)) bus_b ();

  sensor_stream_source #(.DATA_W(32), .DEPTH(512), .ADDR_W(9), .LATENCY(16)) u_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  sensor_stream_source #(.DATA_W(32), .DEPTH(4), .ADDR_W(3), .LATENCY(1)) u_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data;
    logic        e_rdy;
    logic [31:0] e_out;
    logic [2:0]  e_idx;
    logic [15:0] e_cnt;
    logic        e_wr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic en, input logic we, input logic [2:0] addr,
                              input logic [31:0] data, input logic e_rdy, input logic [31:0] e_out,
                              input logic [2:0] e_idx, input logic [15:0] e_cnt, input logic e_wr);
    vec_t v;
    v.rst = r; v.en = en; v.we = we; v.addr = addr; v.data = data;
    v.e_rdy = e_rdy; v.e_out = e_out; v.e_idx = e_idx; v.e_cnt = e_cnt; v.e_wr = e_wr;
    return v;
  endfunction

  function automatic logic [31:0] av(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic rdy, input logic [31:0] out,
                         input logic [31:0] idx, input logic [31:0] cnt, input logic wr);
    chk({tag, "_rdy"}, 32'(bus_a.sensor_ready), 32'(rdy));
    chk({tag, "_out"}, bus_a.sensor_out, out);
    chk({tag, "_idx"}, 32'(bus_a.rd_idx), idx);
    chk({tag, "_cnt"}, 32'(bus_a.sample_cnt), cnt);
    chk({tag, "_wrap"}, 32'(bus_a.wrapped), 32'(wr));
  endtask

  task automatic step_a(input logic en);
    bus_a.sensor_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [8:0] addr, input logic [31:0] data);
    bus_a.load_we   = 1'b1;
    bus_a.load_addr = addr;
    bus_a.load_data = data;
    step_a(1'b0);
    bus_a.load_we   = 1'b0;
  endtask

  // Pulse-only check for a stretch of enabled or disabled cycles with no emit expected
  task automatic run_quiet_a(input string tag, input int n, input logic en);
    for (int k = 0; k < n; k++) begin
      step_a(en);
      chk(tag, 32'(bus_a.sensor_ready), 32'd0);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.sensor_en = 1'b0; bus_a.load_we = 1'b0; bus_a.load_addr = '0; bus_a.load_data = '0;
    bus_b.sensor_en = 1'b0; bus_b.load_we = 1'b0; bus_b.load_addr = '0; bus_b.load_data = '0;

    // ---------------- main instance: DEPTH=512, LATENCY=16 ----------------
    step_a(1'b0);
    rst_a = 1'b0;
    check_a("a_reset", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) load_a(9'(i), av(i));
    check_a("a_preload", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

    // Continuous enable: pulses after edges 16, 32, 48, 64 carrying A0..A3
    for (int k = 1; k <= 64; k++) begin
      step_a(1'b1);
      chk("t1_rdy", 32'(bus_a.sensor_ready), ((k % 16) == 0) ? 32'd1 : 32'd0);
      chk("t1_out", bus_a.sensor_out, ((k % 16) == 0) ? av(k / 16 - 1) : 32'd0);
    end
    check_a("t1_end", 1'b1, av(3), 32'd4, 32'd4, 1'b0);

    // 10 enabled, 5 paused, then enabled: emit on overall edge 21
    for (int k = 1; k <= 21; k++) begin
      step_a((k <= 10) || (k > 15));
      chk("t2_rdy", 32'(bus_a.sensor_ready), (k == 21) ? 32'd1 : 32'd0);
      chk("t2_out", bus_a.sensor_out, (k == 21) ? av(4) : 32'd0);
    end
    check_a("t2_end", 1'b1, av(4), 32'd5, 32'd5, 1'b0);

    // Reset at lat_cnt=12, rd_idx=5; a load during reset must be dropped
    run_quiet_a("t3_pre_rdy", 12, 1'b1);
    rst_a = 1'b1;
    bus_a.load_we = 1'b1; bus_a.load_addr = 9'd0; bus_a.load_data = 32'hDEAD_BEEF;
    step_a(1'b1);
    rst_a = 1'b0;
    bus_a.load_we = 1'b0;
    check_a("t3_rst", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    run_quiet_a("t3_wait_rdy", 15, 1'b1);
    step_a(1'b1);
    check_a("t3_emit", 1'b1, av(0), 32'd1, 32'd1, 1'b0);

    // Disable on the edge lat_cnt reaches LATENCY-1: hold, then emit on first enabled edge
    run_quiet_a("t4_cnt_rdy", 15, 1'b1);
    run_quiet_a("t4_hold_rdy", 3, 1'b0);
    step_a(1'b1);
    check_a("t4_emit", 1'b1, av(1), 32'd2, 32'd2, 1'b0);
    step_a(1'b0);
    check_a("t4_after", 1'b0, 32'd0, 32'd2, 32'd2, 1'b0);

    // ---------------- small instance: DEPTH=4, LATENCY=1 ----------------
    tbl.push_back(mk(1, 0, 0, 3'd0, 32'h0,  0, 32'h0,  3'd0, 16'd0,  0));
    tbl.push_back(mk(0, 0, 1, 3'd0, 32'h1,  0, 32'h0,  3'd0, 16'd0,  0));
    tbl.push_back(mk(0, 0, 1, 3'd1, 32'h2,  0, 32'h0,  3'd0, 16'd0,  0));
    tbl.push_back(mk(0, 0, 1, 3'd2, 32'h3,  0, 32'h0,  3'd0, 16'd0,  0));
    tbl.push_back(mk(0, 0, 1, 3'd3, 32'h4,  0, 32'h0,  3'd0, 16'd0,  0));
    tbl.push_back(mk(0, 0, 1, 3'd4, 32'h99, 0, 32'h0,  3'd0, 16'd0,  0));
    tbl.push_back(mk(0, 1, 0, 3'd0, 32'h0,  1, 32'h1,  3'd1, 16'd1,  0));
    tbl.push_back(mk(0, 1, 0, 3'd0, 32'h0,  1, 32'h2,  3'd2, 16'd2,  0));
    tbl.push_back(mk(0, 1, 0, 3'd0, 32'h0,  1, 32'h3,  3'd3, 16'd3,  0));
    tbl.push_back(mk(0, 1, 0, 3'd0, 32'h0,  1, 32'h4,  3'd0, 16'd4,  1));
    tbl.push_back(mk(0, 1, 0, 3'd0, 32'h0,  1, 32'h1,  3'd1, 16'd5,  1));
    tbl.push_back(mk(0, 1, 0, 3'd0, 32'h0,  1, 32'h2,  3'd2, 16'd6,  1));
    tbl.push_back(mk(0, 0, 1, 3'd2, 32'h11, 0, 32'h0,  3'd2, 16'd6,  1));
    tbl.push_back(mk(0, 1, 1, 3'd2, 32'h22, 1, 32'h11, 3'd3, 16'd7,  1));
    tbl.push_back(mk(0, 1, 0, 3'd0, 32'h0,  1, 32'h4,  3'd0, 16'd8,  1));
    tbl.push_back(mk(0, 1, 0, 3'd0, 32'h0,  1, 32'h1,  3'd1, 16'd9,  1));
    tbl.push_back(mk(0, 1, 0, 3'd0, 32'h0,  1, 32'h2,  3'd2, 16'd10, 1));
    tbl.push_back(mk(0, 1, 0, 3'd0, 32'h0,  1, 32'h22, 3'd3, 16'd11, 1));
    tbl.push_back(mk(1, 1, 1, 3'd0, 32'h77, 0, 32'h0,  3'd0, 16'd0,  0));
    tbl.push_back(mk(0, 1, 0, 3'd0, 32'h0,  1, 32'h1,  3'd1, 16'd1,  0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 32'h0,  0, 32'h0,  3'd1, 16'd1,  0));

    foreach (tbl[i]) begin
      rst_b           = tbl[i].rst;
      bus_b.sensor_en = tbl[i].en;
      bus_b.load_we   = tbl[i].we;
      bus_b.load_addr = tbl[i].addr;
      bus_b.load_data = tbl[i].data;
      @(posedge clk);
      #1;
      chk($sformatf("b%0d_rdy", i), 32'(bus_b.sensor_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("b%0d_out", i), bus_b.sensor_out, tbl[i].e_out);
      chk($sformatf("b%0d_idx", i), 32'(bus_b.rd_idx), 32'(tbl[i].e_idx));
      chk($sformatf("b%0d_cnt", i), 32'(bus_b.sample_cnt), 32'(tbl[i].e_cnt));
      chk($sformatf("b%0d_wrap", i), 32'(bus_b.wrapped), 32'(tbl[i].e_wr));
    end
    rst_b = 1'b0;
    bus_b.load_we = 1'b0;

    // Saturation: from count 1, 65534 more samples reach FFFF, then it sticks
    bus_b.sensor_en = 1'b1;
    for (int k = 0; k < 65534; k++) begin
      @(posedge clk);
    end
    #1;
    chk("sat_reach", 32'(bus_b.sample_cnt), 32'h0000_FFFF);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
    end
    #1;
    chk("sat_hold", 32'(bus_b.sample_cnt), 32'h0000_FFFF);
    chk("sat_rdy", 32'(bus_b.sensor_ready), 32'd1);
    chk("sat_wrap", 32'(bus_b.wrapped), 32'd1);
    bus_b.sensor_en = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_idle_rdy", 32'(bus_b.sensor_ready), 32'd0);
    chk("sat_idle_out", bus_b.sensor_out, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
